// File: rtl/switch_egress_queue.sv
// Per-output-port egress buffer: a first-word-fall-through FIFO fed by the switch output lane.
// It counts packets dropped on overflow and packets misrouted to this port, both saturating.
module switch_egress_queue #(
  parameter logic [3:0]  PORT_MASK = 4'b0001,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic [3:0]               source_in,
  input  logic [3:0]               target_in,
  input  logic [7:0]               data_in,
  output logic                     valid_out,
  input  logic                     ready_out,
  output logic [3:0]               source_out,
  output logic [3:0]               target_out,
  output logic [7:0]               data_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         misroute_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ENT_W = 16;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rptr, wptr, rptr_nxt, wptr_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic [ENT_W-1:0] in_ent, head_nxt;
  logic             match, pop, full, wr, drop, misroute;

  // Next-state decode for pointers, level and the registered head entry
  always_comb begin
    match     = valid_in && ((target_in & PORT_MASK) != 4'b0000);
    pop       = valid_out && ready_out;
    full      = (level == LVL_W'(DEPTH));
    wr        = match && (!full || pop);
    drop      = match && full && !pop;
    misroute  = valid_in && !match;
    in_ent    = {source_in, target_in, data_in};
    rptr_nxt  = pop ? rptr + PTR_W'(1) : rptr;
    wptr_nxt  = wr  ? wptr + PTR_W'(1) : wptr;
    level_nxt = level;
    if (wr && !pop) begin
      level_nxt = level + LVL_W'(1);
    end else if (pop && !wr) begin
      level_nxt = level - LVL_W'(1);
    end
    head_nxt = '0;
    // The new head is the incoming packet when every older entry is gone
    if (level_nxt != '0) begin
      if (wr && (rptr_nxt == wptr)) begin
        head_nxt = in_ent;
      end else begin
        head_nxt = mem[rptr_nxt];
      end
    end
  end

  // Storage array, no reset needed: contents are only visible through the head register
  always_ff @(posedge clk) begin
    if (rst_n && wr) begin
      mem[wptr] <= in_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr         <= '0;
      wptr         <= '0;
      level        <= '0;
      drop_cnt     <= '0;
      misroute_cnt <= '0;
      valid_out    <= 1'b0;
      source_out   <= '0;
      target_out   <= '0;
      data_out     <= '0;
    end else begin
      rptr      <= rptr_nxt;
      wptr      <= wptr_nxt;
      level     <= level_nxt;
      valid_out <= (level_nxt != '0);
      {source_out, target_out, data_out} <= head_nxt;
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
      if (misroute && (misroute_cnt != '1)) begin
        misroute_cnt <= misroute_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_switch_egress_queue.sv
// Randomized and directed bench for switch_egress_queue, checked against a queue-based reference model.
module tb_switch_egress_queue;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = 16;
  localparam logic [3:0]  MASK   = 4'b0001;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [3:0]  source_in;
  logic [3:0]  target_in;
  logic [7:0]  data_in;
  logic        valid_out;
  logic        ready_out;
  logic [3:0]  source_out;
  logic [3:0]  target_out;
  logic [7:0]  data_out;
  logic [3:0]  level;
  logic [15:0] drop_cnt;
  logic [15:0] misroute_cnt;

  switch_egress_queue #(.PORT_MASK(MASK), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .source_in(source_in),
    .target_in(target_in), .data_in(data_in), .valid_out(valid_out),
    .ready_out(ready_out), .source_out(source_out), .target_out(target_out),
    .data_out(data_out), .level(level), .drop_cnt(drop_cnt),
    .misroute_cnt(misroute_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: packet queue plus two saturating counters
  logic [15:0] mq[$];
  int          m_drop = 0;
  int          m_misr = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rs, input logic v, input logic [3:0] tgt,
                            input logic [15:0] ent, input logic rdy);
    int  old_size;
    bit  m;
    bit  p;
    if (!rs) begin
      mq.delete();
      m_drop = 0;
      m_misr = 0;
      return;
    end
    old_size = mq.size();
    m = v && ((tgt & MASK) != 4'b0000);
    p = (old_size > 0) && rdy;
    if (p) void'(mq.pop_front());
    if (m) begin
      if (old_size < int'(DEPTH) || p) mq.push_back(ent);
      else if (m_drop < int'(CNT_MAX)) m_drop++;
    end
    if (v && !m && m_misr < int'(CNT_MAX)) m_misr++;
  endtask

  task automatic check_outputs();
    logic [15:0] head;
    head = (mq.size() > 0) ? mq[0] : 16'h0000;
    check_eq("valid_out", 32'(valid_out), 32'(mq.size() > 0));
    check_eq("source_out", 32'(source_out), 32'(head[15:12]));
    check_eq("target_out", 32'(target_out), 32'(head[11:8]));
    check_eq("data_out", 32'(data_out), 32'(head[7:0]));
    check_eq("level", 32'(level), 32'(mq.size()));
    check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check_eq("misroute_cnt", 32'(misroute_cnt), 32'(m_misr));
  endtask

  // One clock: drive inputs, advance model, check after the edge
  task automatic step(input logic rs, input logic v, input logic [3:0] src,
                      input logic [3:0] tgt, input logic [7:0] d, input logic rdy);
    rst_n     = rs;
    valid_in  = v;
    source_in = src;
    target_in = tgt;
    data_in   = d;
    ready_out = rdy;
    model_edge(rs, v, tgt, {src, tgt, d}, rdy);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic rdy);
    step(1'b1, 1'b0, 4'h0, 4'h0, 8'h00, rdy);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; source_in = '0; target_in = '0; data_in = '0; ready_out = 1'b0;

    // Reset then idle
    step(1'b0, 1'b1, 4'h3, 4'h1, 8'h11, 1'b0);
    step(1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0);
    idle(1'b0);
    check_eq("rst_valid", 32'(valid_out), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);

    // Single packet with ready high: visible next cycle, popped at the following edge
    step(1'b1, 1'b1, 4'd2, 4'b0001, 8'hA5, 1'b1);
    check_eq("single_valid", 32'(valid_out), 32'd1);
    check_eq("single_data", 32'(data_out), 32'hA5);
    check_eq("single_src", 32'(source_out), 32'd2);
    idle(1'b1);
    check_eq("single_level", 32'(level), 32'd0);

    // Fill and overflow
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 4'h1, 4'b0001, 8'(i), 1'b0);
    check_eq("fill_level", 32'(level), 32'd8);
    check_eq("fill_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 8; i++) begin
      check_eq("drain_order", 32'(data_out), 32'(i));
      idle(1'b1);
    end
    check_eq("drain_empty", 32'(valid_out), 32'd0);

    // Full with simultaneous pop and write
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 4'h5, 4'b0011, 8'(8'h10 + 8'(i)), 1'b0);
    step(1'b1, 1'b1, 4'h6, 4'b0001, 8'h77, 1'b1);
    check_eq("fullpop_level", 32'(level), 32'd8);
    check_eq("fullpop_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 7; i++) idle(1'b1);
    check_eq("fullpop_last", 32'(data_out), 32'h77);
    idle(1'b1);

    // Misroute and broadcast
    step(1'b1, 1'b1, 4'h2, 4'b0100, 8'h55, 1'b0);
    check_eq("misr_cnt", 32'(misroute_cnt), 32'd1);
    check_eq("misr_level", 32'(level), 32'd0);
    step(1'b1, 1'b1, 4'h2, 4'b1111, 8'h3C, 1'b0);
    check_eq("bcast_level", 32'(level), 32'd1);

    // Back-pressure: head stable while ready low, exactly one pop
    idle(1'b0);
    idle(1'b0);
    check_eq("bp_head", 32'(data_out), 32'h3C);
    idle(1'b1);
    idle(1'b0);
    check_eq("bp_popped", 32'(level), 32'd0);

    // Reset mid-operation with level=5, drop_cnt=3
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 4'h7, 4'b0001, 8'(8'h40 + 8'(i)), 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check_eq("pre_rst_level", 32'(level), 32'd5);
    check_eq("pre_rst_drop", 32'(drop_cnt), 32'd3);
    step(1'b0, 1'b1, 4'h7, 4'b0001, 8'hEE, 1'b1);
    check_eq("mid_rst_level", 32'(level), 32'd0);
    check_eq("mid_rst_drop", 32'(drop_cnt), 32'd0);
    check_eq("mid_rst_misr", 32'(misroute_cnt), 32'd0);
    check_eq("mid_rst_data", 32'(data_out), 32'd0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) != 0), ($urandom_range(0, 2) != 0),
           4'($urandom), 4'($urandom), 8'($urandom), ($urandom_range(0, 2) == 0));
    end

    // Drop counter saturation
    step(1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 4'h1, 4'b0001, 8'(i), 1'b0);
    for (int i = 0; i < 65540; i++) step(1'b1, 1'b1, 4'h1, 4'b1001, 8'hF0, 1'b0);
    check_eq("drop_sat", 32'(drop_cnt), 32'h0000FFFF);
    check_eq("sat_level", 32'(level), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/switch_egress_queue.md
Name: switch_egress_queue

Overview:
- Per-output-port buffer directly downstream of the 4-port switch core; one instance per port.
- Accepts packets the switch presents on its output lane (valid/source/target/data, single-cycle valid, no backpressure) and stores them in a first-word-fall-through (FWFT) FIFO.
- Delivers stored packets to the port sink over a valid/ready handshake.
- Counts packets discarded on overflow, and packets misrouted to this port.

Parameters:
- PORT_MASK, 4'b0001, one-hot identity of this output port; a packet belongs here iff (target & PORT_MASK) != 0.
- DEPTH, 8, FIFO entries; power of two, 2..64.
- CNT_W, 16, width of the drop and misroute counters.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- valid_in  input  1  switch output lane packet strobe, one cycle per packet
- source_in  input  4  packet source field
- target_in  input  4  packet target field (one-hot destination mask)
- data_in  input  8  packet payload
- valid_out  output  1  packet available to sink
- ready_out  input  1  sink accepts packet this cycle
- source_out  output  4  head packet source
- target_out  output  4  head packet target
- data_out  output  8  head packet payload
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- drop_cnt  output  CNT_W  packets discarded because the FIFO was full
- misroute_cnt  output  CNT_W  packets discarded because the target did not include PORT_MASK

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - read/write pointers, level, drop_cnt and misroute_cnt go to 0.
  - valid_out=0; source_out, target_out and data_out=0.
  - Reset mid-operation discards all stored packets; valid_in sampled in the reset cycle is ignored.
- Definitions:
  - match = valid_in & ((target_in & PORT_MASK) != 0).
  - pop = valid_out & ready_out.
  - full = (level == DEPTH).
- Write:
  - If match & (!full | pop), store {source_in, target_in, data_in} at the write pointer and advance it.
  - Pointers wrap modulo DEPTH.
- Simultaneous pop and write when full:
  - Both happen; level stays DEPTH; no drop.
- Overflow:
  - If match & full & !pop, the packet is discarded and drop_cnt increments.
- Misroute:
  - If valid_in & !match, the packet is discarded and misroute_cnt increments.
  - A misroute never also counts as a drop.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Output (FWFT):
  - valid_out = (level != 0), driven from registered state.
  - While valid_out=1, source_out, target_out and data_out show the head entry.
  - While valid_out=0, all three are 0.
- Latency:
  - A packet written at edge N into an empty queue gives valid_out=1 in the cycle after edge N.
  - No combinational path from valid_in or data inputs to any output.
- Handshake:
  - Pop advances the read pointer at the edge.
  - The head must hold stable while valid_out=1 and ready_out=0.
  - ready_out is ignored when valid_out=0; asserting it while empty has no effect.
- Level update per edge:
  - +1 on write without pop; −1 on pop without write; unchanged on both or neither.
- Ordering: strict FIFO; no reordering, no duplication.
- Broadcast targets are accepted like any other matching packet and stored unmodified, e.g. 4'b1111 matches every PORT_MASK.

Test Plan:
- Reset then idle: valid_out=0, level=0, drop_cnt=0, misroute_cnt=0, all data outputs 0.
- Single packet, PORT_MASK=4'b0001, ready_out=1:
  - Stimulus: one packet {src=2, tgt=4'b0001, data=8'hA5} at edge N.
  - Required: valid_out=1 with those fields in cycle N+1, popped at edge N+1, level back to 0.
- Fill and overflow, ready_out=0:
  - Stimulus: 10 matching packets with data 0..9, DEPTH=8.
  - Required: level=8, drop_cnt=2; then ready_out=1 drains data 0..7 in order.
- Full with simultaneous pop:
  - Stimulus: queue full, ready_out=1, new packet data=8'h77 arriving in the same cycle.
  - Required: accepted, level stays 8, drop_cnt unchanged, 8'h77 emerges last.
- Misroute:
  - Stimulus: packet tgt=4'b0100 on the PORT_MASK=4'b0001 instance.
  - Required: not stored, misroute_cnt=1, level unchanged.
  - Stimulus: packet tgt=4'b1111.
  - Required: stored.
- Back-pressure and reset mid-operation:
  - Stimulus: head 8'h3C with ready_out toggled 0/1/0.
  - Required: head stable while ready_out=0; pops exactly once.
  - Stimulus: rst_n=0 for one edge with level=5, drop_cnt=3.
  - Required: all state and outputs 0 in the next cycle.
  - Stimulus: counters preloaded near max by forcing 65,536 overflows.
  - Required: drop_cnt saturates at 16'hFFFF.
